cpu_io_port: RTL and testbench

- Peripheral on the far side of the processor's data_in/data_out port pair.
- Outbound: buffers 16-bit words the CPU writes (OUT instructions) in a small FIFO and drains them to an external consumer over a valid/ready handshake.
- Inbound: accepts words from an external producer over valid/ready and presents them to the CPU for IN instructions, with a 2-entry buffer.
- Sticky error flags record CPU writes to a full port and CPU reads from an empty port.

---
 rtl/cpu_io_port.sv | 158 +++++++++++++++
 tb/tb_cpu_io_port.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_port.sv
// CPU-side I/O peripheral: outbound word FIFO drained over valid/ready, and a
// 2-entry inbound buffer filled over valid/ready and popped by CPU IN reads.
module cpu_io_port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cpu_out_data,
    input  logic             cpu_out_we,
    output logic             cpu_out_full,
    output logic [WIDTH-1:0] cpu_in_data,
    output logic             cpu_in_valid,
    input  logic             cpu_in_re,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             ovf,
    output logic             udf,
    input  logic             clr_err
);

    typedef enum logic [1:0] {
        IN_EMPTY = 2'd0,
        IN_ONE   = 2'd1,
        IN_TWO   = 2'd2
    } in_state_e;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_s, pop_s;

    in_state_e        state_q, state_d;
    logic [WIDTH-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic             accept_s, in_pop_s;

    logic             ovf_q, ovf_d, udf_q, udf_d;

    // Full is judged on start-of-cycle count, so a same-cycle pop never rescues a push.
    assign cpu_out_full = (count_q == FULL_CNT);
    assign tx_valid     = (count_q != {(AW+1){1'b0}});
    assign tx_data      = tx_valid ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
    assign push_s       = cpu_out_we && !cpu_out_full;
    assign pop_s        = tx_valid && tx_ready;

    assign rx_ready     = (state_q != IN_TWO);
    assign cpu_in_valid = (state_q != IN_EMPTY);
    assign cpu_in_data  = cpu_in_valid ? slot0_q : {WIDTH{1'b0}};
    assign accept_s     = rx_valid && rx_ready;
    assign in_pop_s     = cpu_in_re && cpu_in_valid;

    assign ovf = ovf_q;
    assign udf = udf_q;

    // Outbound pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Inbound buffer: slot0 is always the head presented to the CPU.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            IN_EMPTY: begin
                if (accept_s) begin
                    state_d = IN_ONE;
                    slot0_d = rx_data;
                end else begin
                    state_d = IN_EMPTY;
                end
            end
            IN_ONE: begin
                if (accept_s && !in_pop_s) begin
                    state_d = IN_TWO;
                    slot1_d = rx_data;
                end else if (in_pop_s && !accept_s) begin
                    state_d = IN_EMPTY;
                end else if (in_pop_s && accept_s) begin
                    slot0_d = rx_data;
                end else begin
                    state_d = IN_ONE;
                end
            end
            IN_TWO: begin
                if (in_pop_s) begin
                    state_d = IN_ONE;
                    slot0_d = slot1_q;
                end else begin
                    state_d = IN_TWO;
                end
            end
            default: state_d = IN_EMPTY;
        endcase
    end

    // Sticky error flags: a fresh error outranks a same-cycle clear.
    always_comb begin
        ovf_d = (clr_err ? 1'b0 : ovf_q) | (cpu_out_we && cpu_out_full);
        udf_d = (clr_err ? 1'b0 : udf_q) | (cpu_in_re && !cpu_in_valid);
    end

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= cpu_out_data;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            state_q  <= IN_EMPTY;
            slot0_q  <= {WIDTH{1'b0}};
            slot1_q  <= {WIDTH{1'b0}};
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule

// File: tb/tb_cpu_io_port.sv
// Bench for cpu_io_port: directed vector table, hand sequences, and random
// traffic checked against a queue-based reference model.
module tb_cpu_io_port;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] cpu_out_data, cpu_in_data, tx_data, rx_data;
    logic             cpu_out_we, cpu_out_full, cpu_in_valid, cpu_in_re;
    logic             tx_valid, tx_ready, rx_valid, rx_ready, ovf, udf, clr_err;

    cpu_io_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cpu_out_data(cpu_out_data), .cpu_out_we(cpu_out_we), .cpu_out_full(cpu_out_full),
        .cpu_in_data(cpu_in_data), .cpu_in_valid(cpu_in_valid), .cpu_in_re(cpu_in_re),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ovf(ovf), .udf(udf), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: plain queues plus the two sticky flags
    logic [WIDTH-1:0] m_out [$];
    logic [WIDTH-1:0] m_in  [$];
    logic             m_ovf, m_udf;

    typedef struct {
        logic we; logic [15:0] wd; logic re; logic txr; logic rxv; logic [15:0] rxd; logic clr;
        logic full; logic txv; logic [15:0] txd; logic inv; logic [15:0] ind;
        logic rxr; logic e_ovf; logic e_udf;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, "_full"}, {31'd0, cpu_out_full}, {31'd0, m_out.size() == DEPTH});
        chk({tag, "_txv"},  {31'd0, tx_valid},     {31'd0, m_out.size() != 0});
        chk({tag, "_txd"},  {16'd0, tx_data},      {16'd0, (m_out.size() != 0) ? m_out[0] : 16'h0000});
        chk({tag, "_inv"},  {31'd0, cpu_in_valid}, {31'd0, m_in.size() != 0});
        chk({tag, "_ind"},  {16'd0, cpu_in_data},  {16'd0, (m_in.size() != 0) ? m_in[0] : 16'h0000});
        chk({tag, "_rxr"},  {31'd0, rx_ready},     {31'd0, m_in.size() < 2});
        chk({tag, "_ovf"},  {31'd0, ovf},          {31'd0, m_ovf});
        chk({tag, "_udf"},  {31'd0, udf},          {31'd0, m_udf});
    endtask

    task automatic model_reset();
        m_out.delete();
        m_in.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // drive one cycle of inputs, advance the model, clock, then compare
    task automatic step(input logic we, input logic [15:0] wd, input logic re, input logic txr,
                        input logic rxv, input logic [15:0] rxd, input logic clr, input string tag);
        logic full, o_pop, rxr, acc, i_pop, i_udf;
        cpu_out_we = we; cpu_out_data = wd; cpu_in_re = re; tx_ready = txr;
        rx_valid = rxv; rx_data = rxd; clr_err = clr;
        full  = (m_out.size() == DEPTH);
        o_pop = (m_out.size() != 0) && txr;
        rxr   = (m_in.size() < 2);
        acc   = rxv && rxr;
        i_pop = re && (m_in.size() != 0);
        i_udf = re && (m_in.size() == 0);
        if (o_pop) void'(m_out.pop_front());
        if (we && !full) m_out.push_back(wd);
        if (i_pop) void'(m_in.pop_front());
        if (acc) m_in.push_back(rxd);
        m_ovf = (clr ? 1'b0 : m_ovf) | (we && full);
        m_udf = (clr ? 1'b0 : m_udf) | i_udf;
        @(posedge clk);
        #1;
        model_cmp(tag);
    endtask

    task automatic add(input logic we, input logic [15:0] wd, input logic re, input logic txr,
                       input logic rxv, input logic [15:0] rxd, input logic clr,
                       input logic full, input logic txv, input logic [15:0] txd,
                       input logic inv, input logic [15:0] ind, input logic rxr,
                       input logic e_ovf, input logic e_udf);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.txr = txr; v.rxv = rxv; v.rxd = rxd; v.clr = clr;
        v.full = full; v.txv = txv; v.txd = txd; v.inv = inv; v.ind = ind;
        v.rxr = rxr; v.e_ovf = e_ovf; v.e_udf = e_udf;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0;
        cpu_out_we = 1'b0; cpu_out_data = 16'h0000; cpu_in_re = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 16'h0000; clr_err = 1'b0;
        model_reset();

        //  we wd       re txr rxv rxd     clr | full txv txd      inv ind      rxr ovf udf
        add(1, 16'h0001, 0, 0, 0, 16'h0000, 0,   0, 1, 16'h0001, 0, 16'h0000, 1, 0, 0);
        add(1, 16'h0002, 0, 0, 0, 16'h0000, 0,   0, 1, 16'h0001, 0, 16'h0000, 1, 0, 0);
        add(1, 16'h0003, 0, 0, 0, 16'h0000, 0,   0, 1, 16'h0001, 0, 16'h0000, 1, 0, 0);
        add(1, 16'h0004, 0, 0, 0, 16'h0000, 0,   1, 1, 16'h0001, 0, 16'h0000, 1, 0, 0);
        add(1, 16'h0005, 0, 0, 0, 16'h0000, 0,   1, 1, 16'h0001, 0, 16'h0000, 1, 1, 0);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0,   0, 1, 16'h0002, 0, 16'h0000, 1, 1, 0);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0,   0, 1, 16'h0003, 0, 16'h0000, 1, 1, 0);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0,   0, 1, 16'h0004, 0, 16'h0000, 1, 1, 0);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0);
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 16'hA5A5, 0,   0, 0, 16'h0000, 1, 16'hA5A5, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h5A5A, 0,   0, 0, 16'h0000, 1, 16'hA5A5, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h1234, 0,   0, 0, 16'h0000, 1, 16'hA5A5, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 1, 16'h1234, 0,   0, 0, 16'h0000, 1, 16'h5A5A, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h1234, 0,   0, 0, 16'h0000, 1, 16'h5A5A, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 1, 16'h1234, 1, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h1111, 0,   0, 0, 16'h0000, 1, 16'h1111, 1, 0, 0);
        add(0, 16'h0000, 1, 0, 1, 16'h2222, 0,   0, 0, 16'h0000, 1, 16'h2222, 1, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);

        // reset held with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            cpu_out_we = 1'($urandom_range(0, 1)); cpu_out_data = 16'($urandom);
            cpu_in_re = 1'($urandom_range(0, 1)); tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1)); rx_data = 16'($urandom);
            clr_err = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        model_cmp("inrst");
        cpu_out_we = 1'b0; cpu_in_re = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        step(0, 16'h0000, 0, 0, 0, 16'h0000, 0, "rstrel");

        // directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].txr, tbl[i].rxv, tbl[i].rxd, tbl[i].clr,
                 $sformatf("vm%0d", i));
            chk($sformatf("v%0d_full", i), {31'd0, cpu_out_full}, {31'd0, tbl[i].full});
            chk($sformatf("v%0d_txv", i),  {31'd0, tx_valid},     {31'd0, tbl[i].txv});
            chk($sformatf("v%0d_txd", i),  {16'd0, tx_data},      {16'd0, tbl[i].txd});
            chk($sformatf("v%0d_inv", i),  {31'd0, cpu_in_valid}, {31'd0, tbl[i].inv});
            chk($sformatf("v%0d_ind", i),  {16'd0, cpu_in_data},  {16'd0, tbl[i].ind});
            chk($sformatf("v%0d_rxr", i),  {31'd0, rx_ready},     {31'd0, tbl[i].rxr});
            chk($sformatf("v%0d_ovf", i),  {31'd0, ovf},          {31'd0, tbl[i].e_ovf});
            chk($sformatf("v%0d_udf", i),  {31'd0, udf},          {31'd0, tbl[i].e_udf});
        end

        // simultaneous push/pop with two words resident, forcing pointer wrap
        step(1, 16'h000A, 0, 0, 0, 16'h0000, 0, "pp_ld0");
        step(1, 16'h000B, 0, 0, 0, 16'h0000, 0, "pp_ld1");
        for (int i = 0; i < 10; i++) begin
            step(1, 16'hBEEF, 0, 1, 0, 16'h0000, 0, $sformatf("pp%0d", i));
            chk($sformatf("pp%0d_txd", i), {16'd0, tx_data},
                {16'd0, (i == 0) ? 16'h000B : 16'hBEEF});
            chk($sformatf("pp%0d_full", i), {31'd0, cpu_out_full}, 32'd0);
            chk($sformatf("pp%0d_ovf", i), {31'd0, ovf}, 32'd0);
        end
        step(0, 16'h0000, 0, 1, 0, 16'h0000, 0, "pp_dr0");
        step(0, 16'h0000, 0, 1, 0, 16'h0000, 0, "pp_dr1");
        chk("pp_empty", {31'd0, tx_valid}, 32'd0);

        // asynchronous reset with both directions loaded
        for (int i = 0; i < 3; i++) step(1, 16'(16'h0100 + i), 0, 0, 0, 16'h0000, 0, "ar_out");
        step(0, 16'h0000, 0, 0, 1, 16'h0C01, 0, "ar_in0");
        step(0, 16'h0000, 0, 0, 1, 16'h0C02, 0, "ar_in1");
        rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        model_cmp("arst");
        chk("arst_rxr", {31'd0, rx_ready}, 32'd1);
        chk("arst_txv", {31'd0, tx_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 45), 16'($urandom), 1'($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 50), 16'($urandom),
                 1'($urandom_range(0, 99) < 5), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
